instr_fetch_unit: RTL

Instruction fetch and sequencing stage that sits directly upstream of the processor control unit. It holds a small loadable program memory and a program counter. It drives the shared `din` word and the `run` strobe. It supplies the immediate word for `mvi`, then waits for the control unit's `done` before issuing the next instruction, and halts at the end of the program.

---
 rtl/instr_fetch_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program memory, PC and issue sequencer ahead of the control unit
// Optional breakpoint support is enabled by defining FETCH_BREAKPOINT_EN.
module instr_fetch_unit #(
    parameter int INSTRUCTION_WIDTH = 9,
    parameter int ADDR_WIDTH        = 5,
    parameter int RETIRE_WIDTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_WIDTH:0]          prog_len,
    input  logic                         prog_we,
    input  logic [ADDR_WIDTH-1:0]        prog_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] prog_data,
    input  logic                         done,
`ifdef FETCH_BREAKPOINT_EN
    input  logic                         bp_en,
    input  logic [ADDR_WIDTH-1:0]        bp_addr,
    output logic                         bp_hit,
`endif
    output logic [INSTRUCTION_WIDTH-1:0] din,
    output logic                         run,
    output logic                         busy,
    output logic                         halted,
    output logic [ADDR_WIDTH-1:0]        pc,
    output logic [RETIRE_WIDTH-1:0]      retired
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_IMM   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;
    localparam logic [2:0] S_BREAK = 3'd5;

    localparam logic [ADDR_WIDTH-1:0]   PC_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [RETIRE_WIDTH-1:0] RET_ONE = {{(RETIRE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2:0]              OP_MVI  = 3'b001;

    logic [INSTRUCTION_WIDTH-1:0] mem [2**ADDR_WIDTH];

    logic [2:0]                   state, state_nxt;
    logic [ADDR_WIDTH-1:0]        pc_nxt;
    logic [RETIRE_WIDTH-1:0]      retired_nxt, retired_inc;
    logic [INSTRUCTION_WIDTH-1:0] cur_word;
    logic                         is_mvi;
    logic                         prog_open;
    logic                         bp_stop;
    logic [2:0]                   entry_state;

    assign cur_word    = mem[pc];
    assign is_mvi      = (cur_word[INSTRUCTION_WIDTH-1:INSTRUCTION_WIDTH-3] == OP_MVI);
    assign retired_inc = (retired == {RETIRE_WIDTH{1'b1}}) ? retired : retired + RET_ONE;
    assign prog_open   = (state == S_IDLE) || (state == S_HALT) || (state == S_BREAK);

`ifdef FETCH_BREAKPOINT_EN
    assign bp_stop = bp_en && (pc_nxt == bp_addr);
    assign bp_hit  = (state == S_BREAK);
`else
    assign bp_stop = 1'b0;
`endif

    // Every path into ISSUE except a resume from BREAK goes through this gate.
    assign entry_state = bp_stop ? S_BREAK : S_ISSUE;

    always_ff @(posedge clk) begin
        if (prog_we && prog_open) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        pc_nxt      = pc;
        retired_nxt = retired;
        case (state)
            S_IDLE, S_HALT: begin
                if (start && (state == S_HALT || prog_len != '0)) begin
                    pc_nxt      = '0;
                    retired_nxt = '0;
                end
            end
            S_ISSUE: pc_nxt = pc + PC_ONE;
            S_IMM: begin
                if (done) begin
                    pc_nxt      = pc + PC_ONE;
                    retired_nxt = retired_inc;
                end
            end
            S_WAIT: begin
                if (done) begin
                    retired_nxt = retired_inc;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && prog_len != '0) begin
                    state_nxt = entry_state;
                end
            end
            S_HALT: begin
                if (start) begin
                    state_nxt = entry_state;
                end
            end
            S_ISSUE: state_nxt = is_mvi ? S_IMM : S_WAIT;
            S_IMM, S_WAIT: begin
                if (done) begin
                    state_nxt = ({1'b0, pc_nxt} >= prog_len) ? S_HALT : entry_state;
                end
            end
            S_BREAK: begin
                if (start) begin
                    state_nxt = S_ISSUE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            pc      <= '0;
            retired <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            retired <= retired_nxt;
        end
    end

    assign run    = (state == S_ISSUE);
    assign busy   = (state == S_ISSUE) || (state == S_IMM) || (state == S_WAIT);
    assign halted = (state == S_HALT);
    assign din    = (state == S_ISSUE || state == S_IMM) ? cur_word : '0;

endmodule
